// File: rtl/carsel_mp_sequencer.sv
// rtl/carsel_mp_sequencer.sv - multi-precision adder sequencer around one shared 16-bit carry-select adder
//
// carsel_adder: 16-bit carry-select adder
//   a, b   in   16  addends
//   cin    in    1  carry-in
//   s      out  16  sum
//   co     out   1  carry-out
//
// carsel_mp_sequencer: WORDSx16-bit adder, one slice per cycle, LS slice first
//   WORDS      param    number of 16-bit slices (1..8), W = 16*WORDS
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   request carries a valid operand set
//   in_ready   out  1   request can be accepted (IDLE only)
//   a, b       in   W   operands, sampled at the accept edge
//   cin        in   1   carry-in to slice 0, sampled at the accept edge
//   out_valid  out  1   s/co hold a completed result (DONE)
//   out_ready  in   1   consumer takes the result
//   s          out  W   registered sum
//   co         out  1   registered carry-out of the top slice
//   busy       out  1   high in RUN and DONE

module carsel_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        co
);

    // Four 4-bit blocks; each block precomputes both carry-in cases and the
    // incoming block carry only drives the select muxes.
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < 4; g++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;

        assign r0 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
        assign r1 = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + 5'd1;

        assign s[4*g +: 4] = c[g] ? r1[3:0] : r0[3:0];
        assign c[g+1]      = c[g] ? r1[4]   : r0[4];
    end

    assign co = c[4];

endmodule

module carsel_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] s,
    output logic                co,
    output logic                busy
);

    localparam int W    = 16 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;
    logic [IDXW-1:0] idx;

    logic [15:0]     add_a;
    logic [15:0]     add_b;
    logic [15:0]     add_s;
    logic            add_co;
    logic            last_slice;

    // Single shared adder: only one 16-bit add sits between registers, the
    // inter-slice carry goes through carry_reg.
    assign add_a      = a_reg[16*idx +: 16];
    assign add_b      = b_reg[16*idx +: 16];
    assign last_slice = (idx == LAST_IDX);

    carsel_adder u_adder (
        .a   (add_a),
        .b   (add_b),
        .cin (carry_reg),
        .s   (add_s),
        .co  (add_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_slice) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only, so there is no
    // combinational path from in_valid/out_ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand capture, slice write-back and carry chaining.
    // s and co hold their value outside RUN, which keeps them stable in DONE
    // and leaves the last result visible after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            s         <= '0;
            co        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    s[16*idx +: 16] <= add_s;
                    carry_reg       <= add_co;
                    if (last_slice) begin
                        co <= add_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carsel_mp_sequencer.sv
// tb/tb_carsel_mp_sequencer.sv - scoreboard bench for carsel_mp_sequencer
module tb_carsel_mp_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b1;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = 64'd7;
    logic [W-1:0] b = 64'd9;
    logic         in_ready;
    logic         out_valid;
    logic         co;
    logic         busy;
    logic [W-1:0] s;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic prev_ov = 1'b0;
    logic [W:0] sb[$];

    carsel_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency of each result and scoreboard compare at each handshake.
    always @(negedge clk) begin
        logic [W:0] exp;
        if (!rst && in_valid && in_ready) accept_cyc = cyc + 1;
        if (!rst && out_valid && !prev_ov)
            check("latency", (W+1)'(cyc - accept_cyc), (W+1)'(WORDS));
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h expected none", {co, s});
            end else begin
                exp = sb.pop_front();
                check("result", {co, s}, exp);
            end
        end
        prev_ov = out_valid;
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic [W:0] exp, input bit push);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if (push) sb.push_back(exp);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected in_ready=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        bit seen;

        // 1: reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_in_ready",  (W+1)'(in_ready),  (W+1)'(1));
            check("rst_out_valid", (W+1)'(out_valid), (W+1)'(0));
            check("rst_busy",      (W+1)'(busy),      (W+1)'(0));
            check("rst_s_co",      {co, s},           '0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", (W+1)'(busy), (W+1)'(0));

        // 2-4: back-to-back additions with out_ready held high
        issue(64'd125, 64'd34, 1'b0, 65'd159, 1'b1);
        drain();
        issue(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 65'h0_0000_0000_0001_0000, 1'b1);
        drain();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, {1'b1, 64'd0}, 1'b1);
        drain();

        // 5: backpressure with a competing request
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(64'd1000, 64'd2000, 1'b0, 65'd3000, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("bp_out_valid_rise", (W+1)'(seen), (W+1)'(1));
        @(posedge clk); #1;
        a = 64'd56; b = 64'd11; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", (W+1)'(out_valid), (W+1)'(1));
            check("bp_in_ready",  (W+1)'(in_ready),  (W+1)'(0));
            check("bp_s_co",      {co, s},           65'd3000);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(64'd56, 64'd11, 1'b1, 65'd68, 1'b1);
        drain();

        // 6: reset after two slices discards the operation
        issue(64'd66, 64'd44, 1'b0, '0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",  (W+1)'(in_ready),  (W+1)'(1));
        check("midrst_busy",      (W+1)'(busy),      (W+1)'(0));
        check("midrst_out_valid", (W+1)'(out_valid), (W+1)'(0));
        check("midrst_s_co",      {co, s},           '0);
        repeat (10) @(negedge clk);
        issue(64'd66, 64'd44, 1'b0, 65'd110, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/carsel_mp_sequencer.md
# carsel_mp_sequencer

Multi-precision adder sequencer built around one shared 16-bit `carsel_adder` instance. It accepts a WORDS×16-bit addition through a valid/ready handshake and feeds the adder one 16-bit slice per cycle, least significant slice first. It chains the carry between slices through a register and returns the full sum and carry-out through a second valid/ready handshake. It sits between operand producers and result consumers wherever the datapath needs operands wider than 16 bits without replicating the adder.

## Interface
- WORDS, default 4, number of 16-bit slices; legal range 1..8; operand width W = 16*WORDS.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request carries a valid operand set.
- in_ready  output  1  sequencer can accept a request (high only in IDLE).
- a  input  W  operand A; sampled only at the accept edge.
- b  input  W  operand B; sampled only at the accept edge.
- cin  input  1  carry-in to slice 0; sampled only at the accept edge.
- out_valid  output  1  s and co hold a completed result.
- out_ready  input  1  consumer takes the result.
- s  output  W  sum, registered.
- co  output  1  carry-out of the top slice, registered.
- busy  output  1  high in RUN and DONE.

## Operation
- The block contains exactly one 16-bit `carsel_adder`, with ports a, b, cin, s and co. Its inputs are driven from registered operand slices and the carry register.
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - Accept = in_valid & in_ready. On accept, latch a, b and cin into operand registers, set carry_reg = cin, clear idx to 0 and go to RUN.
- RUN, one slice per cycle:
  - The adder sees A[16*idx +: 16], B[16*idx +: 16] and carry_reg.
  - At the edge, write s[16*idx +: 16] from the adder sum and set carry_reg to the adder carry-out.
  - If idx == WORDS-1: set co to the adder carry-out and go to DONE. Otherwise increment idx.
- DONE:
  - out_valid = 1. s and co are stable for as long as out_valid is high.
  - When out_ready is high at an edge, go to IDLE.
  - in_ready = 0, so a new request cannot overlap a pending result.
- Arithmetic:
  - Unsigned, modulo 2^W.
  - {co, s} = a + b + cin, exact to W+1 bits.
- s is written slice by slice during RUN. It is meaningful only while out_valid = 1.
- After a completed handshake, s and co keep the last result until the next RUN overwrites them.
- in_valid is ignored in RUN and DONE. Requesters hold their request until in_ready is high.
- Reset (rst = 1 at an edge), from any state:
  - state = IDLE, idx = 0, carry_reg = 0, s = 0, co = 0.
  - Any in-flight operation is discarded, and no out_valid is ever produced for it.
- In a cycle with rst = 1, in_valid and out_ready have no effect.

## Timing
- Output values after reset: in_ready = 1, out_valid = 0, busy = 0, s = 0, co = 0.
- Accept edge is E0. Slices are computed at edges E1..E_WORDS. out_valid rises right after E_WORDS, i.e. WORDS cycles after acceptance.
- If out_ready is already high in the first DONE cycle, the result is consumed at edge E_WORDS+1. in_ready is high after that edge, and the next accept can occur at E_WORDS+2.
- Minimum cycle count per operation: WORDS+2 edges from one accept to the next.
- WORDS = 1: a single RUN cycle, then DONE.
- in_ready, out_valid and busy are decoded from registered state only. They have no combinational path from in_valid or out_ready.
- The carry chain between slices passes through carry_reg. The only combinational path through the adder is a single 16-bit add.

## Test plan
1. Reset: hold rst for 2 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, busy = 0, s = 0, co = 0, and nothing is accepted.
2. Basic add (WORDS = 4): a = 125, b = 34, cin = 0 → s = 159, co = 0, with out_valid high exactly 4 cycles after the accept edge and out_ready held high.
3. Cross-slice carry: a = 64'h0000_0000_0000_FFFF, b = 1, cin = 0 → s = 64'h0000_0000_0001_0000, co = 0.
4. Full carry ripple: a = 64'hFFFF_FFFF_FFFF_FFFF, b = 0, cin = 1 → s = 0, co = 1.
5. Backpressure: hold out_ready low for 5 cycles after out_valid rises → s, co and out_valid stay stable, in_ready = 0, and a concurrent in_valid with a = 56, b = 11, cin = 1 is not accepted. After out_ready goes high, that request is accepted and returns s = 68, co = 0.
6. Reset mid-RUN: assert rst after 2 slices of a = 66, b = 44 → out_valid never rises, in_ready = 1 after the reset edge. A following request a = 66, b = 44, cin = 0 yields s = 110.
